// File: rtl/i2c_tx_sequencer.sv
// Byte-serialising transmit sequencer for an I2C slave read response:
// drives SDA low-enable MSB first on SCL-low strobes and samples the master ACK.
module i2c_tx_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  input  logic       shift_strobe,
  input  logic       sample_strobe,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic [7:0] bytes_sent,
  output logic       nack,
  output logic       done,
  output logic       underrun
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    SHIFT    = 2'd2,
    ACK_WAIT = 2'd3
  } state_t;

  state_t     state_r, state_s;
  logic [7:0] shreg_r, shreg_s;
  logic [2:0] bit_idx_r, bit_idx_s;
  logic       last_bit_r, last_bit_s;
  logic       sda_oe_s;
  logic [7:0] bytes_sent_s;
  logic       nack_s, done_s, underrun_s;

  // Next-state and next-output decode; stop outranks every strobe and the handshake.
  always_comb begin
    state_s      = state_r;
    shreg_s      = shreg_r;
    bit_idx_s    = bit_idx_r;
    last_bit_s   = last_bit_r;
    sda_oe_s     = sda_oe;
    bytes_sent_s = bytes_sent;
    nack_s       = 1'b0;
    done_s       = 1'b0;
    underrun_s   = 1'b0;
    if (state_r == IDLE) begin
      if (start) begin
        bytes_sent_s = 8'd0;
        state_s      = LOAD;
      end else begin
        state_s = IDLE;
      end
    end else if (stop) begin
      sda_oe_s = 1'b0;
      done_s   = 1'b1;
      state_s  = IDLE;
    end else begin
      case (state_r)
        LOAD: begin
          if (shift_strobe) begin
            // Strobe already in the SCL-low phase: bit 7 goes out now (all-ones if no data).
            shreg_s    = byte_valid ? byte_data : 8'hFF;
            sda_oe_s   = ~shreg_s[7];
            underrun_s = ~byte_valid;
            bit_idx_s  = 3'd6;
            last_bit_s = 1'b0;
            state_s    = SHIFT;
          end else if (byte_valid) begin
            shreg_s    = byte_data;
            bit_idx_s  = 3'd7;
            last_bit_s = 1'b0;
            state_s    = SHIFT;
          end else begin
            state_s = LOAD;
          end
        end
        SHIFT: begin
          if (shift_strobe) begin
            if (last_bit_r) begin
              sda_oe_s   = 1'b0;
              last_bit_s = 1'b0;
              state_s    = ACK_WAIT;
            end else begin
              sda_oe_s   = ~shreg_r[bit_idx_r];
              bit_idx_s  = bit_idx_r - 3'd1;
              last_bit_s = (bit_idx_r == 3'd0);
            end
          end else begin
            state_s = SHIFT;
          end
        end
        ACK_WAIT: begin
          if (sample_strobe) begin
            if (!sda_in) begin
              bytes_sent_s = bytes_sent + 8'd1;
              state_s      = LOAD;
            end else begin
              sda_oe_s = 1'b0;
              nack_s   = 1'b1;
              done_s   = 1'b1;
              state_s  = IDLE;
            end
          end else begin
            state_s = ACK_WAIT;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      shreg_r    <= 8'd0;
      bit_idx_r  <= 3'd7;
      last_bit_r <= 1'b0;
      sda_oe     <= 1'b0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      bytes_sent <= 8'd0;
      nack       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_r    <= state_s;
      shreg_r    <= shreg_s;
      bit_idx_r  <= bit_idx_s;
      last_bit_r <= last_bit_s;
      sda_oe     <= sda_oe_s;
      byte_ready <= (state_s == LOAD);
      busy       <= (state_s != IDLE);
      bytes_sent <= bytes_sent_s;
      nack       <= nack_s;
      done       <= done_s;
      underrun   <= underrun_s;
    end
  end

endmodule

// File: tb/tb_i2c_tx_sequencer.sv
// Directed bench for i2c_tx_sequencer: transaction-level model compared every
// cycle, plus literal expectations for the worked scenarios.
module tb_i2c_tx_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stop, byte_valid, shift_strobe, sample_strobe, sda_in;
  logic [7:0] byte_data;
  logic       byte_ready, sda_oe, busy, nack, done, underrun;
  logic [7:0] bytes_sent;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  i2c_tx_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .shift_strobe(shift_strobe), .sample_strobe(sample_strobe), .sda_in(sda_in),
    .sda_oe(sda_oe), .busy(busy), .bytes_sent(bytes_sent),
    .nack(nack), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Model phases: idle, waiting for a byte, byte held with n strobes seen, awaiting ACK.
  localparam int P_IDLE = 0, P_LOAD = 1, P_BYTE = 2, P_ACK = 3;

  typedef struct {
    int         phase;
    int         n;
    logic [7:0] data;
    logic       sda;
    logic [7:0] sent;
    logic       nack;
    logic       done;
    logic       under;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t cur, logic rst, logic st, logic sp,
                                        logic bv, logic [7:0] bd, logic sh, logic sa,
                                        logic sdi);
    model_t r;
    r       = cur;
    r.nack  = 1'b0;
    r.done  = 1'b0;
    r.under = 1'b0;
    if (rst) begin
      r = '{P_IDLE, 0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    end else if (cur.phase == P_IDLE) begin
      if (st) begin
        r.phase = P_LOAD;
        r.sent  = 8'h00;
      end
    end else if (sp) begin
      r.phase = P_IDLE;
      r.sda   = 1'b0;
      r.done  = 1'b1;
    end else if (cur.phase == P_LOAD) begin
      if (sh) begin
        r.data  = bv ? bd : 8'hFF;
        r.under = !bv;
        r.n     = 1;
        r.sda   = !r.data[7];
        r.phase = P_BYTE;
      end else if (bv) begin
        r.data  = bd;
        r.n     = 0;
        r.phase = P_BYTE;
      end
    end else if (cur.phase == P_BYTE) begin
      if (sh) begin
        r.n = cur.n + 1;
        if (r.n == 9) begin
          r.sda   = 1'b0;
          r.phase = P_ACK;
        end else begin
          r.sda = !cur.data[8 - r.n];
        end
      end
    end else if (sa) begin
      if (!sdi) begin
        r.sent  = cur.sent + 8'd1;
        r.phase = P_LOAD;
      end else begin
        r.sda   = 1'b0;
        r.nack  = 1'b1;
        r.done  = 1'b1;
        r.phase = P_IDLE;
      end
    end
    return r;
  endfunction

  always @(posedge clk)
    m <= model_next(m, reset, start, stop, byte_valid, byte_data,
                    shift_strobe, sample_strobe, sda_in);

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("model sda_oe", {7'd0, sda_oe}, {7'd0, m.sda});
      chk("model byte_ready", {7'd0, byte_ready}, {7'd0, m.phase == P_LOAD});
      chk("model busy", {7'd0, busy}, {7'd0, m.phase != P_IDLE});
      chk("model bytes_sent", bytes_sent, m.sent);
      chk("model nack", {7'd0, nack}, {7'd0, m.nack});
      chk("model done", {7'd0, done}, {7'd0, m.done});
      chk("model underrun", {7'd0, underrun}, {7'd0, m.under});
    end
  end

  task automatic tick();
    @(negedge clk);
    reset         = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
    byte_valid    = 1'b0;
    shift_strobe  = 1'b0;
    sample_strobe = 1'b0;
  endtask

  // One byte from LOAD: offer it, 9 spaced strobes with ignored noise in the gaps, then the ACK sample.
  task automatic send_byte(input logic [7:0] d, input logic ack);
    byte_valid = 1'b1;
    byte_data  = d;
    tick();
    for (int i = 0; i < 9; i++) begin
      shift_strobe = 1'b1;
      tick();
      byte_valid = 1'b1;
      byte_data  = ~d;
      start      = 1'b1;
      tick();
    end
    sample_strobe = 1'b1;
    sda_in        = !ack;
    tick();
    sda_in = 1'b1;
  endtask

  logic exp_a5 [9];

  initial begin
    exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    reset = 1'b1; start = 1'b0; stop = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    shift_strobe = 1'b0; sample_strobe = 1'b0; sda_in = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_en = 1'b1;
    chk("reset sda_oe", {7'd0, sda_oe}, 8'd0);
    chk("reset busy", {7'd0, busy}, 8'd0);
    chk("reset bytes_sent", bytes_sent, 8'd0);

    // Single byte A5, NACKed; a simultaneous sample strobe mid-byte must be ignored.
    start = 1'b1; tick();
    chk("a5 busy", {7'd0, busy}, 8'd1);
    chk("a5 byte_ready", {7'd0, byte_ready}, 8'd1);
    byte_valid = 1'b1; byte_data = 8'hA5; tick();
    chk("a5 ready low in shift", {7'd0, byte_ready}, 8'd0);
    for (int i = 0; i < 9; i++) begin
      shift_strobe  = 1'b1;
      sample_strobe = (i == 3);
      tick();
      chk("a5 bit", {7'd0, sda_oe}, {7'd0, exp_a5[i]});
      tick();
    end
    sample_strobe = 1'b1; sda_in = 1'b1; tick();
    chk("a5 nack", {7'd0, nack}, 8'd1);
    chk("a5 done", {7'd0, done}, 8'd1);
    chk("a5 bytes_sent", bytes_sent, 8'd0);

    // Two bytes: ACK then NACK.
    start = 1'b1; tick();
    send_byte(8'h3C, 1'b1);
    chk("two bytes_sent", bytes_sent, 8'd1);
    chk("two ready in load", {7'd0, byte_ready}, 8'd1);
    send_byte(8'h81, 1'b0);
    chk("two nack", {7'd0, nack}, 8'd1);

    // Underrun: strobe in LOAD with no data releases all bits.
    start = 1'b1; tick();
    shift_strobe = 1'b1; tick();
    chk("underrun pulse", {7'd0, underrun}, 8'd1);
    chk("underrun bit7", {7'd0, sda_oe}, 8'd0);
    for (int i = 0; i < 8; i++) begin
      shift_strobe = 1'b1; tick();
      chk("underrun bits", {7'd0, sda_oe}, 8'd0);
    end
    sample_strobe = 1'b1; sda_in = 1'b0; tick();
    sda_in = 1'b1;
    stop = 1'b1; tick();
    chk("underrun stop done", {7'd0, done}, 8'd1);

    // Data and strobe in the same cycle.
    start = 1'b1; tick();
    byte_valid = 1'b1; byte_data = 8'h00; shift_strobe = 1'b1; tick();
    chk("simul bit7", {7'd0, sda_oe}, 8'd1);
    for (int i = 0; i < 8; i++) begin
      shift_strobe = 1'b1; tick();
    end
    sample_strobe = 1'b1; sda_in = 1'b0; tick();
    sda_in = 1'b1;
    chk("simul ack count", bytes_sent, 8'd1);
    stop = 1'b1; tick();

    // Abort after the 4th bit of 00, with every strobe also asserted.
    start = 1'b1; tick();
    send_byte(8'h55, 1'b1);
    byte_valid = 1'b1; byte_data = 8'h00; tick();
    for (int i = 0; i < 4; i++) begin
      shift_strobe = 1'b1; tick(); tick();
    end
    chk("abort pre sda", {7'd0, sda_oe}, 8'd1);
    stop = 1'b1; shift_strobe = 1'b1; sample_strobe = 1'b1; tick();
    chk("abort sda_oe", {7'd0, sda_oe}, 8'd0);
    chk("abort busy", {7'd0, busy}, 8'd0);
    chk("abort done", {7'd0, done}, 8'd1);
    chk("abort nack", {7'd0, nack}, 8'd0);
    chk("abort bytes_sent held", bytes_sent, 8'd1);
    stop = 1'b1; tick();
    chk("idle stop no done", {7'd0, done}, 8'd0);
    start = 1'b1; tick();
    chk("restart bytes_sent", bytes_sent, 8'd0);
    chk("restart busy", {7'd0, busy}, 8'd1);
    send_byte(8'hC3, 1'b0);

    // 256 ACKed bytes wrap the counter, then reset mid-SHIFT.
    start = 1'b1; tick();
    for (int k = 0; k < 256; k++) begin
      send_byte(8'(k), 1'b1);
      if (k == 0) chk("wrap first", bytes_sent, 8'd1);
    end
    chk("wrap to zero", bytes_sent, 8'd0);
    byte_valid = 1'b1; byte_data = 8'h9A; tick();
    for (int i = 0; i < 3; i++) begin
      shift_strobe = 1'b1; tick();
    end
    chk("pre reset sda", {7'd0, sda_oe}, 8'd1);
    reset = 1'b1; start = 1'b1; stop = 1'b1; shift_strobe = 1'b1; sample_strobe = 1'b1;
    tick();
    chk("midreset sda_oe", {7'd0, sda_oe}, 8'd0);
    chk("midreset busy", {7'd0, busy}, 8'd0);
    chk("midreset byte_ready", {7'd0, byte_ready}, 8'd0);
    chk("midreset bytes_sent", bytes_sent, 8'd0);
    chk("midreset done", {7'd0, done}, 8'd0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
